// File: rtl/minterm_pkg.sv
// Shared types and constants for the minterm scanner.
package minterm_pkg;
  localparam int N_IN = 5;
  localparam logic [31:0] DEFAULT_TRUTH = 32'h7BE6_4D5E;

  typedef enum logic [1:0] {IDLE, SCAN, HOLD, DONE} state_t;
endpackage

// File: rtl/truth_lut.sv
// Combinational 5-input truth table: Y is bit A of TRUTH.
module truth_lut
  import minterm_pkg::*;
#(
  parameter logic [31:0] TRUTH = DEFAULT_TRUTH
) (
  input  logic [N_IN-1:0] A,
  output logic            Y
);
  assign Y = TRUTH[A];
endmodule

// File: rtl/minterm_scanner.sv
// Sweeps all 32 input codes and streams every code whose output equals sel
// (ON-set or OFF-set) over valid/ready; one transfer per HOLD handshake.
module minterm_scanner
  import minterm_pkg::*;
#(
  parameter logic [31:0] TRUTH = DEFAULT_TRUTH
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       sel,
  output logic       m_valid,
  output logic [4:0] m_index,
  input  logic       m_ready,
  output logic       busy,
  output logic       done,
  output logic [5:0] count
);
  state_t          state_q, state_d;
  logic [N_IN-1:0] code_q;
  logic            sel_q;
  logic            y;
  logic            accept, code_inc, emit, xfer;

  truth_lut #(.TRUTH(TRUTH)) u_lut (
    .A(code_q),
    .Y(y)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Code 31 never increments: both SCAN and HOLD route it straight to DONE.
  always_comb begin
    state_d  = state_q;
    accept   = 1'b0;
    code_inc = 1'b0;
    emit     = 1'b0;
    xfer     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          accept  = 1'b1;
          state_d = SCAN;
        end
      end
      SCAN: begin
        if (y == sel_q) begin
          emit    = 1'b1;
          state_d = HOLD;
        end else if (code_q == 5'd31) begin
          state_d = DONE;
        end else begin
          code_inc = 1'b1;
        end
      end
      HOLD: begin
        if (m_valid && m_ready) begin
          xfer = 1'b1;
          if (code_q == 5'd31) begin
            state_d = DONE;
          end else begin
            code_inc = 1'b1;
            state_d  = SCAN;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      code_q  <= '0;
      sel_q   <= 1'b0;
      m_valid <= 1'b0;
      m_index <= '0;
      count   <= '0;
    end else begin
      if (accept) begin
        code_q <= '0;
        count  <= '0;
        sel_q  <= sel;
      end
      if (code_inc) code_q <= code_q + 5'd1;
      if (emit) begin
        m_valid <= 1'b1;
        m_index <= code_q;
      end
      if (xfer) begin
        m_valid <= 1'b0;
        count   <= count + 6'd1;
      end
    end
  end

  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);
endmodule

// File: tb/tb_minterm_scanner.sv
// Scoreboard bench for minterm_scanner: default table plus an all-zero table.
module tb_minterm_scanner;
  logic       clk = 1'b0;
  logic       reset;
  logic       start_a, start_b, sel, m_ready;
  logic       va, vb, busya, busyb, donea, doneb;
  logic [4:0] ia, ib;
  logic [5:0] cnta, cntb;

  logic       which;
  logic       o_valid, o_busy, o_done;
  logic [4:0] o_index;
  logic [5:0] o_count;

  int n_chk  = 0;
  int n_pass = 0;
  int q[$];

  always #5 clk = ~clk;

  minterm_scanner dut (
    .clk(clk), .reset(reset), .start(start_a), .sel(sel),
    .m_valid(va), .m_index(ia), .m_ready(m_ready),
    .busy(busya), .done(donea), .count(cnta)
  );

  minterm_scanner #(.TRUTH(32'h0)) dut0 (
    .clk(clk), .reset(reset), .start(start_b), .sel(sel),
    .m_valid(vb), .m_index(ib), .m_ready(m_ready),
    .busy(busyb), .done(doneb), .count(cntb)
  );

  always_comb begin
    o_valid = which ? vb    : va;
    o_index = which ? ib    : ia;
    o_busy  = which ? busyb : busya;
    o_done  = which ? doneb : donea;
    o_count = which ? cntb  : cnta;
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  // mode 0: ready held high; 1: ready toggles each cycle; 2: ready high with start/sel noise
  task automatic run_scan(input logic b, input logic s, input int mode,
                          input int exp_cnt, input int exp_done);
    int         cyc;
    int         last_xfer;
    logic       stalled;
    logic       got_done;
    logic [4:0] held;
    which = b;
    @(posedge clk); #1;
    sel     = s;
    m_ready = (mode != 1);
    if (b) start_b = 1'b1; else start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    start_b = 1'b0;
    cyc = 0; last_xfer = -1; stalled = 1'b0; got_done = 1'b0; held = '0;
    chk("busy_after_start", o_busy, 1);
    chk("count_cleared", o_count, 0);
    while (!got_done && cyc < 300) begin
      @(negedge clk);
      if (stalled) begin
        chk("stall_valid", o_valid, 1);
        chk("stall_index", o_index, held);
      end
      stalled = o_valid && !m_ready;
      held    = o_index;
      if (o_valid && m_ready) begin
        if (q.size() == 0) chk("xfer_unexpected", q.size(), 1);
        else chk("m_index", o_index, q.pop_front());
        last_xfer = cyc;
      end
      if (o_done) begin
        got_done = 1'b1;
        chk("count", o_count, exp_cnt);
        chk("leftover", q.size(), 0);
        if (exp_done >= 0) chk("done_cycle", cyc, exp_done);
        if (mode == 1) chk("done_after_xfer", cyc, last_xfer + 1);
        if (mode == 2) begin
          start_a = 1'b0;
          start_b = 1'b0;
        end
      end else begin
        @(posedge clk); #1;
        cyc++;
        if (mode == 1) m_ready = ~m_ready;
        if (mode == 2) begin
          if (b) start_b = 1'($urandom_range(0, 1));
          else   start_a = 1'($urandom_range(0, 1));
          sel = 1'($urandom_range(0, 1));
        end
      end
    end
    chk("done_seen", got_done, 1);
  endtask

  int on_set[20]  = '{1, 2, 3, 4, 6, 8, 10, 11, 14, 17, 18, 21, 22, 23, 24, 25, 27, 28, 29, 30};
  int off_set[12] = '{0, 5, 7, 9, 12, 13, 15, 16, 19, 20, 26, 31};

  task automatic push_on();
    foreach (on_set[i]) q.push_back(on_set[i]);
  endtask

  task automatic push_off();
    foreach (off_set[i]) q.push_back(off_set[i]);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic found;
    reset = 1'b1; start_a = 1'b0; start_b = 1'b0; sel = 1'b0; m_ready = 1'b0; which = 1'b0;
    #12;
    chk("rst_valid", va, 0);
    chk("rst_index", ia, 0);
    chk("rst_busy", busya, 0);
    chk("rst_done", donea, 0);
    chk("rst_count", cnta, 0);
    chk("rst_busy_b", busyb, 0);
    reset = 1'b0;

    // ON-set, full throughput, then back-to-back OFF-set with toggling ready
    push_on();
    run_scan(1'b0, 1'b1, 0, 20, 52);
    push_off();
    run_scan(1'b0, 1'b0, 1, 12, -1);

    // start/sel noise during the scan must not disturb it
    push_on();
    run_scan(1'b0, 1'b1, 2, 20, 52);
    repeat (4) begin
      @(negedge clk);
      chk("extra_done", donea, 0);
      chk("idle_after_noise", busya, 0);
    end

    // asynchronous reset while holding index 12
    which = 1'b0;
    @(posedge clk); #1;
    sel = 1'b0; m_ready = 1'b1; start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(posedge clk); #1;
      if (va && ia == 5'd12) begin
        m_ready = 1'b0;
        found = 1'b1;
      end
    end
    chk("reach_index12", found, 1);
    @(posedge clk); #1;
    chk("pre_rst_valid", va, 1);
    chk("pre_rst_count", cnta, 4);
    #1 reset = 1'b1;
    #1;
    chk("async_valid", va, 0);
    chk("async_busy", busya, 0);
    chk("async_count", cnta, 0);
    chk("async_done", donea, 0);
    chk("async_index", ia, 0);
    reset = 1'b0;
    push_on();
    run_scan(1'b0, 1'b1, 0, 20, 52);

    // all-zero table: nothing in the ON-set, everything in the OFF-set
    run_scan(1'b1, 1'b1, 0, 0, 32);
    for (int i = 0; i < 32; i++) q.push_back(i);
    run_scan(1'b1, 1'b0, 0, 32, 64);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
